// File: rtl/spi_target_mmio.sv
// spi_target_mmio
// ---------------
// SPI target (slave) with an MMIO register front-end. SCLK, MOSI and CS_N are
// oversampled in the clk domain, so the whole block runs on clk. Received
// bytes land in an RX FIFO. The byte to send is staged in a single holding
// register.
//
// Parameters
//   RX_DEPTH  RX FIFO entries (power of two, 2..16)
//   TX_IDLE   byte shifted out when nothing is staged
//   ADDR_W    MMIO address width (>= 8; only addr[7:2] is decoded)
//
// Ports
//   clk, rst_n              system clock, asynchronous active-low reset
//   spi_sclk/mosi/cs_n      pins from the external controller
//   spi_miso, spi_miso_oe   MISO data and pad enable
//   mmio_*                  valid/we/addr/wdata/wstrb in, rdata/ready out
//   irq_o                   interrupt (level)
//
// Register map
//   0x00 STATUS  R/W1C  [0] RX_NE [1] RX_FULL [2] TX_EMPTY [3] OVR [4] SEL
//                       [12:8] RX_COUNT
//   0x04 CTRL    RW     [0] CPHA [8] EN [9] FLUSH (self-clearing)
//                       [16] IRQ_RX_EN [17] IRQ_OVR_EN
//   0x08 TXDATA  W      stage a byte
//   0x0C RXDATA  R      pop the head byte
//
// Build option
//   SPI_TGT_IRQ_EN  when defined, enables irq_o and CTRL[17:16]. When it is
//                   undefined, irq_o is tied to 0 and CTRL[17:16] read as 0.
module spi_target_mmio #(
   parameter int unsigned RX_DEPTH = 4,
   parameter logic [7:0]  TX_IDLE  = 8'hFF,
   parameter int unsigned ADDR_W   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              spi_sclk,
   input  logic              spi_mosi,
   input  logic              spi_cs_n,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   input  logic              mmio_valid,
   input  logic              mmio_we,
   input  logic [ADDR_W-1:0] mmio_addr,
   input  logic [31:0]       mmio_wdata,
   input  logic [3:0]        mmio_wstrb,
   output logic [31:0]       mmio_rdata,
   output logic              mmio_ready,
   output logic              irq_o
);

   localparam int unsigned PTR_W = $clog2(RX_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [7:0] ADDR_STATUS = 8'h00;
   localparam logic [7:0] ADDR_CTRL   = 8'h04;
   localparam logic [7:0] ADDR_TXDATA = 8'h08;
   localparam logic [7:0] ADDR_RXDATA = 8'h0C;

   typedef enum logic {ST_IDLE, ST_SEL} state_e;

   state_e           state_q, state_d;
   logic [2:0]       sclk_sync_q, sclk_sync_d;
   logic [2:0]       cs_sync_q, cs_sync_d;
   logic [1:0]       mosi_sync_q, mosi_sync_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [6:0]       shift_in_q, shift_in_d;
   logic [7:0]       tx_shift_q, tx_shift_d;
   logic             skip_q, skip_d;
   logic [7:0]       tx_hold_q, tx_hold_d;
   logic             tx_valid_q, tx_valid_d;
   logic             cpha_q, cpha_d;
   logic             en_q, en_d;
   logic             ovr_q, ovr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
   logic             spi_miso_q, spi_miso_d;
   logic             irq_q, irq_d;
   logic [7:0]       rx_mem [RX_DEPTH];

   logic [7:0] addr8;
   logic       rd_fire, wr_fire;
   logic       sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic       sample_edge, shift_edge;
   logic [7:0] load_byte, push_byte;
   logic       tx_load, push, push_ok, pop, flush, rx_full, rx_ne;
   logic       ctrl_wr, status_wr, txdata_wr;
   logic [31:0] status_word, ctrl_word;
   logic       unused_bits;

   assign addr8     = {mmio_addr[7:2], 2'b00};
   assign rd_fire   = mmio_valid & ~mmio_we;
   assign wr_fire   = mmio_valid & mmio_we;
   assign ctrl_wr   = wr_fire && (addr8 == ADDR_CTRL);
   assign status_wr = wr_fire && (addr8 == ADDR_STATUS);
   assign txdata_wr = wr_fire && (addr8 == ADDR_TXDATA) && mmio_wstrb[0];
   assign flush     = ctrl_wr & mmio_wstrb[1] & mmio_wdata[9];

   // Edges are taken between the 2nd sync stage and the extra history flop.
   assign sclk_rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
   assign sclk_fall   = ~sclk_sync_q[1] & sclk_sync_q[2];
   assign cs_rise     = cs_sync_q[1] & ~cs_sync_q[2];
   assign cs_fall     = ~cs_sync_q[1] & cs_sync_q[2];
   assign sample_edge = cpha_q ? sclk_fall : sclk_rise;
   assign shift_edge  = cpha_q ? sclk_rise : sclk_fall;

   // The reload always sees the pre-write holding state.
   assign load_byte = tx_valid_q ? tx_hold_q : TX_IDLE;
   assign push_byte = {shift_in_q, mosi_sync_q[1]};

   assign rx_full = (rx_cnt_q == CNT_W'(RX_DEPTH));
   assign rx_ne   = (rx_cnt_q != '0);
   assign push_ok = push & ~rx_full;
   assign pop     = rd_fire && (addr8 == ADDR_RXDATA) && rx_ne;

   assign status_word = {19'h0, 5'(rx_cnt_q), 3'h0, ~cs_sync_q[1], ovr_q,
                         ~tx_valid_q, rx_full, rx_ne};

`ifdef SPI_TGT_IRQ_EN
   logic irq_rx_en_q, irq_rx_en_d;
   logic irq_ovr_en_q, irq_ovr_en_d;
   assign ctrl_word = {14'h0, irq_ovr_en_q, irq_rx_en_q, 6'h0, 1'b0, en_q, 7'h0, cpha_q};
`else
   assign ctrl_word = {16'h0, 6'h0, 1'b0, en_q, 7'h0, cpha_q};
`endif

   assign mmio_ready  = 1'b1;
   assign spi_miso    = spi_miso_q;
   assign spi_miso_oe = ~cs_sync_q[1] & en_q;
   assign irq_o       = irq_q;
   assign unused_bits = ^{mmio_wdata, mmio_wstrb, mmio_addr};

   always_comb begin
      mmio_rdata = '0;
      if (rd_fire) begin
         case (addr8)
            ADDR_STATUS: mmio_rdata = status_word;
            ADDR_CTRL:   mmio_rdata = ctrl_word;
            ADDR_RXDATA: if (rx_ne) mmio_rdata = {24'h0, rx_mem[rd_ptr_q]};
            default:     mmio_rdata = '0;
         endcase
      end
   end

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      state_d     = state_q;
      sclk_sync_d = {sclk_sync_q[1:0], spi_sclk};
      cs_sync_d   = {cs_sync_q[1:0], spi_cs_n};
      mosi_sync_d = {mosi_sync_q[0], spi_mosi};
      bit_cnt_d   = bit_cnt_q;
      shift_in_d  = shift_in_q;
      tx_shift_d  = tx_shift_q;
      skip_d      = skip_q;
      tx_hold_d   = tx_hold_q;
      tx_valid_d  = tx_valid_q;
      cpha_d      = cpha_q;
      en_d        = en_q;
      ovr_d       = ovr_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      rx_cnt_d    = rx_cnt_q;
      tx_load     = 1'b0;
      push        = 1'b0;

      // Frame engine
      case (state_q)
         ST_IDLE: begin
            if (cs_fall && en_q) begin
               state_d    = ST_SEL;
               bit_cnt_d  = '0;
               tx_shift_d = load_byte;
               tx_load    = 1'b1;
               // CPHA=1 opens with a shift edge that must not move bit 7.
               skip_d     = cpha_q;
            end
         end
         ST_SEL: begin
            if (cs_rise || !en_q) begin
               state_d = ST_IDLE;
            end else if (sample_edge) begin
               shift_in_d = push_byte[6:0];
               bit_cnt_d  = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  push       = 1'b1;
                  tx_shift_d = load_byte;
                  tx_load    = 1'b1;
                  // The shift edge right after a byte boundary would drop the new bit 7.
                  skip_d     = 1'b1;
               end
            end else if (shift_edge) begin
               if (skip_q) skip_d = 1'b0;
               else        tx_shift_d = {tx_shift_q[6:0], 1'b0};
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Holding register: a bus write wins over the valid-clear from a reload.
      if (tx_load)   tx_valid_d = 1'b0;
      if (txdata_wr) begin
         tx_valid_d = 1'b1;
         tx_hold_d  = mmio_wdata[7:0];
      end

      if (ctrl_wr) begin
         if (mmio_wstrb[0]) cpha_d = mmio_wdata[0];
         if (mmio_wstrb[1]) en_d   = mmio_wdata[8];
      end

      // A new overflow in the clearing cycle stays visible.
      if (status_wr && mmio_wstrb[0] && mmio_wdata[3]) ovr_d = 1'b0;
      if (push && rx_full) ovr_d = 1'b1;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         rx_cnt_d = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
         rx_cnt_d = rx_cnt_q + CNT_W'(push_ok) - CNT_W'(pop);
      end

      spi_miso_d = (state_q == ST_SEL) & tx_shift_q[7];
   end

`ifdef SPI_TGT_IRQ_EN
   always_comb begin
      irq_rx_en_d  = irq_rx_en_q;
      irq_ovr_en_d = irq_ovr_en_q;
      if (ctrl_wr && mmio_wstrb[2]) begin
         irq_rx_en_d  = mmio_wdata[16];
         irq_ovr_en_d = mmio_wdata[17];
      end
      irq_d = (irq_rx_en_q & rx_ne) | (irq_ovr_en_q & ovr_q);
   end
`else
   assign irq_d = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         sclk_sync_q <= 3'b000;
         cs_sync_q   <= 3'b111;
         mosi_sync_q <= 2'b00;
         bit_cnt_q   <= '0;
         shift_in_q  <= '0;
         tx_shift_q  <= '0;
         skip_q      <= 1'b0;
         tx_hold_q   <= '0;
         tx_valid_q  <= 1'b0;
         cpha_q      <= 1'b0;
         en_q        <= 1'b1;
         ovr_q       <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         rx_cnt_q    <= '0;
         spi_miso_q  <= 1'b0;
         irq_q       <= 1'b0;
`ifdef SPI_TGT_IRQ_EN
         irq_rx_en_q  <= 1'b0;
         irq_ovr_en_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         sclk_sync_q <= sclk_sync_d;
         cs_sync_q   <= cs_sync_d;
         mosi_sync_q <= mosi_sync_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_in_q  <= shift_in_d;
         tx_shift_q  <= tx_shift_d;
         skip_q      <= skip_d;
         tx_hold_q   <= tx_hold_d;
         tx_valid_q  <= tx_valid_d;
         cpha_q      <= cpha_d;
         en_q        <= en_d;
         ovr_q       <= ovr_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         rx_cnt_q    <= rx_cnt_d;
         spi_miso_q  <= spi_miso_d;
         irq_q       <= irq_d;
`ifdef SPI_TGT_IRQ_EN
         irq_rx_en_q  <= irq_rx_en_d;
         irq_ovr_en_q <= irq_ovr_en_d;
`endif
      end
   end

   // NOTE: FIFO storage has no reset; the pointers and count alone define its contents.
   always_ff @(posedge clk) begin
      if (push_ok) rx_mem[wr_ptr_q] <= push_byte;
   end

endmodule

// File: tb/tb_spi_target_mmio.sv
`timescale 1ns/1ps
module tb_spi_target_mmio;
   localparam int RX_DEPTH = 4;
   localparam int H        = 8;   // SCLK half period in clk cycles

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        spi_sclk = 1'b0;
   logic        spi_mosi = 1'b0;
   logic        spi_cs_n = 1'b1;
   logic        mmio_valid = 1'b0;
   logic        mmio_we = 1'b0;
   logic [7:0]  mmio_addr = 8'h0;
   logic [31:0] mmio_wdata = 32'h0;
   logic [3:0]  mmio_wstrb = 4'h0;
   logic        spi_miso, spi_miso_oe, mmio_ready, irq_o;
   logic [31:0] mmio_rdata;

   spi_target_mmio #(.RX_DEPTH(RX_DEPTH), .TX_IDLE(8'hFF), .ADDR_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
      .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
      .mmio_valid(mmio_valid), .mmio_we(mmio_we), .mmio_addr(mmio_addr),
      .mmio_wdata(mmio_wdata), .mmio_wstrb(mmio_wstrb),
      .mmio_rdata(mmio_rdata), .mmio_ready(mmio_ready), .irq_o(irq_o)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Scoreboard queues
   logic [31:0] exp_rd_q[$];
   logic [7:0]  exp_miso_q[$];

   // Reference model state
   logic [7:0] m_rx[$];
   logic       m_ovr = 1'b0;
   logic       m_tx_valid = 1'b0;
   logic [7:0] m_tx_hold = 8'h0;
   logic       m_cpha = 1'b0;
   logic       m_en = 1'b1;
   logic       m_irq_rx = 1'b0;
   logic       m_irq_ovr = 1'b0;

   logic       tb_cpha = 1'b0;
   logic [7:0] frame_data[8];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%08h expected=%08h @%0t", name, got, exp, $time);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] model_status();
      return {19'h0, 5'(m_rx.size()), 3'h0, 1'b0, m_ovr, ~m_tx_valid,
              (m_rx.size() == RX_DEPTH), (m_rx.size() != 0)};
   endfunction

   function automatic logic [31:0] model_ctrl();
      return {14'h0, m_irq_ovr, m_irq_rx, 6'h0, 1'b0, m_en, 7'h0, m_cpha};
   endfunction

   // Every frame start and every completed byte takes the staged byte (or idle).
   function automatic logic [7:0] model_load();
      if (m_tx_valid) begin
         m_tx_valid = 1'b0;
         return m_tx_hold;
      end
      return 8'hFF;
   endfunction

   function automatic void model_rx(input logic [7:0] b);
      if (m_rx.size() < RX_DEPTH) m_rx.push_back(b);
      else m_ovr = 1'b1;
   endfunction

   function automatic void model_reset();
      m_rx.delete();
      m_ovr = 1'b0; m_tx_valid = 1'b0; m_tx_hold = 8'h0;
      m_cpha = 1'b0; m_en = 1'b1; m_irq_rx = 1'b0; m_irq_ovr = 1'b0;
   endfunction

   // Read monitor: compares every read cycle against the queued expectation.
   always @(negedge clk) begin
      if (mmio_valid && !mmio_we) begin
         if (exp_rd_q.size() == 0) begin
            total++; bad++;
            $display("FAIL rd_unexpected got=%08h expected=none", mmio_rdata);
         end else begin
            check($sformatf("read@%02h", mmio_addr), mmio_rdata, exp_rd_q.pop_front());
         end
      end
   end

   // MISO monitor: acts as the controller's receiver.
   logic       prev_sclk = 1'b0;
   logic       prev_cs = 1'b1;
   int         mon_cnt = 0;
   logic [7:0] mon_byte = 8'h0;
   always @(spi_sclk or spi_cs_n) begin
      if (prev_cs && !spi_cs_n) begin
         mon_cnt = 0;
      end else if (!spi_cs_n && (spi_sclk != prev_sclk) && (spi_sclk == !tb_cpha)) begin
         mon_byte = {mon_byte[6:0], spi_miso};
         mon_cnt++;
         if (mon_cnt == 8) begin
            mon_cnt = 0;
            if (exp_miso_q.size() == 0) begin
               total++; bad++;
               $display("FAIL miso_unexpected got=%02h expected=none", mon_byte);
            end else begin
               check("miso_byte", {24'h0, mon_byte}, {24'h0, exp_miso_q.pop_front()});
            end
         end
      end
      prev_sclk = spi_sclk;
      prev_cs   = spi_cs_n;
   end

   task automatic bus_write(input logic [7:0] addr, input logic [31:0] d, input logic [3:0] strb);
      mmio_valid = 1'b1; mmio_we = 1'b1; mmio_addr = addr;
      mmio_wdata = d; mmio_wstrb = strb;
      wait_clk(1);
      mmio_valid = 1'b0; mmio_we = 1'b0; mmio_wstrb = 4'h0;
      case (addr & 8'hFC)
         8'h00: if (strb[0] && d[3]) m_ovr = 1'b0;
         8'h04: begin
            if (strb[0]) m_cpha = d[0];
            if (strb[1]) begin
               m_en = d[8];
               if (d[9]) m_rx.delete();
            end
`ifdef SPI_TGT_IRQ_EN
            if (strb[2]) begin
               m_irq_rx = d[16]; m_irq_ovr = d[17];
            end
`endif
         end
         8'h08: if (strb[0]) begin
            m_tx_valid = 1'b1; m_tx_hold = d[7:0];
         end
         default: ;
      endcase
   endtask

   task automatic bus_read(input logic [7:0] addr);
      logic [31:0] e;
      case (addr & 8'hFC)
         8'h00:   e = model_status();
         8'h04:   e = model_ctrl();
         8'h0C:   e = (m_rx.size() != 0) ? {24'h0, m_rx.pop_front()} : 32'h0;
         default: e = 32'h0;
      endcase
      exp_rd_q.push_back(e);
      mmio_valid = 1'b1; mmio_we = 1'b0; mmio_addr = addr;
      wait_clk(1);
      mmio_valid = 1'b0;
   endtask

   // Runs a frame of nbytes from frame_data; if abort_bits>0 the last byte is cut short.
   task automatic spi_frame(input int nbytes, input int abort_bits);
      logic [7:0] cur;
      int nb;
      tb_cpha = m_cpha;
      cur = model_load();
      spi_cs_n = 1'b0;
      wait_clk(H);
      check("miso_oe_in_frame", {31'h0, spi_miso_oe}, 32'h1);
      for (int i = 0; i < nbytes; i++) begin
         nb = (i == nbytes - 1 && abort_bits > 0) ? abort_bits : 8;
         if (nb == 8) exp_miso_q.push_back(cur);
         for (int b = 7; b > 7 - nb; b--) begin
            if (!m_cpha) begin
               spi_mosi = frame_data[i][b];
               wait_clk(H); spi_sclk = 1'b1;
               wait_clk(H); spi_sclk = 1'b0;
            end else begin
               spi_sclk = 1'b1; spi_mosi = frame_data[i][b];
               wait_clk(H); spi_sclk = 1'b0;
               wait_clk(H);
            end
         end
         if (nb == 8) begin
            model_rx(frame_data[i]);
            cur = model_load();
         end
      end
      wait_clk(H);
      spi_cs_n = 1'b1; spi_mosi = 1'b0;
      wait_clk(8);
   endtask

   initial begin
      #800_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #2;
      check("rst_miso", {31'h0, spi_miso}, 32'h0);
      check("rst_miso_oe", {31'h0, spi_miso_oe}, 32'h0);
      check("rst_irq", {31'h0, irq_o}, 32'h0);
      check("rst_rdata", mmio_rdata, 32'h0);
      check("ready", {31'h0, mmio_ready}, 32'h1);
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(4);

      bus_read(8'h04);
      bus_read(8'h00);
      bus_read(8'h08);
      bus_read(8'h10);
      bus_read(8'h0C);
      bus_read(8'h0E);

      // Basic receive, CPHA=0
      frame_data[0] = 8'hA5;
      spi_frame(1, 0);
      bus_read(8'h00);
      bus_read(8'h0C);
      bus_read(8'h00);

      // Basic transmit: 0x3C then idle
      bus_write(8'h08, 32'h3C, 4'h1);
      bus_read(8'h00);
      frame_data[0] = 8'h11; frame_data[1] = 8'h22;
      spi_frame(2, 0);
      bus_read(8'h00);
      bus_read(8'h0C);
      bus_read(8'h0C);

      // Overflow
      for (int i = 0; i < 5; i++) frame_data[i] = 8'(i + 1);
      spi_frame(5, 0);
      bus_read(8'h00);
      for (int i = 0; i < 4; i++) bus_read(8'h0C);
      bus_read(8'h00);
      bus_write(8'h00, 32'h8, 4'h1);
      bus_read(8'h00);

      // Abort after 5 bits, then a clean byte
      frame_data[0] = 8'hFF;
      spi_frame(1, 5);
      bus_read(8'h00);
      frame_data[0] = 8'h81;
      spi_frame(1, 0);
      bus_read(8'h0C);

      // CPHA=1
      bus_write(8'h04, 32'h101, 4'h3);
      bus_write(8'h08, 32'hC3, 4'h1);
      frame_data[0] = 8'h5A;
      spi_frame(1, 0);
      bus_read(8'h0C);
      bus_write(8'h04, 32'h100, 4'h3);

      // Staged byte overwritten before the frame
      bus_write(8'h08, 32'h44, 4'h1);
      bus_write(8'h08, 32'h99, 4'h1);
      frame_data[0] = 8'h0F;
      spi_frame(1, 0);
      bus_read(8'h0C);

      // Flush
      frame_data[0] = 8'h12; frame_data[1] = 8'h34;
      spi_frame(2, 0);
      bus_write(8'h04, 32'h300, 4'h3);
      bus_read(8'h00);
      bus_read(8'h04);

      // Byte strobes and IRQ enable bits
      bus_write(8'h04, 32'h0, 4'h1);
      bus_read(8'h04);
      bus_write(8'h04, 32'h0003_0101, 4'hF);
      bus_read(8'h04);
      bus_write(8'h04, 32'h0000_0100, 4'hF);
      bus_write(8'h14, 32'hFFFF_FFFF, 4'hF);
      bus_read(8'h04);

      // Interrupt
      bus_write(8'h04, 32'h0001_0100, 4'hF);
      frame_data[0] = 8'h77;
      spi_frame(1, 0);
`ifdef SPI_TGT_IRQ_EN
      check("irq_rx_set", {31'h0, irq_o}, 32'h1);
      bus_read(8'h0C);
      wait_clk(1);
      check("irq_rx_clear", {31'h0, irq_o}, 32'h0);
`else
      check("irq_tied_low", {31'h0, irq_o}, 32'h0);
      bus_read(8'h0C);
`endif
      bus_write(8'h04, 32'h0000_0100, 4'hF);

      // Randomized frames against the model
      for (int it = 0; it < 30; it++) begin
         int nbytes, abort_bits;
         if ($urandom_range(0, 2) == 0) bus_write(8'h08, $urandom, 4'h1);
         if ($urandom_range(0, 3) == 0) bus_write(8'h08, $urandom, 4'h1);
         bus_write(8'h04, {23'h0, 1'b1, 7'h0, 1'($urandom_range(0, 1))}, 4'h3);
         nbytes = $urandom_range(1, 3);
         abort_bits = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 0;
         for (int i = 0; i < nbytes; i++) frame_data[i] = 8'($urandom);
         spi_frame(nbytes, abort_bits);
         bus_read(8'h00);
         for (int r = $urandom_range(0, 3); r > 0; r--) bus_read(8'h0C);
         if (m_ovr && $urandom_range(0, 1) == 1) bus_write(8'h00, 32'h8, 4'h1);
      end

      // Reset asserted mid-frame
      bus_write(8'h04, 32'h100, 4'h3);
      tb_cpha = 1'b0;
      spi_cs_n = 1'b0;
      wait_clk(H);
      for (int b = 0; b < 3; b++) begin
         spi_mosi = 1'b1;
         wait_clk(H); spi_sclk = 1'b1;
         wait_clk(H); spi_sclk = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      check("midrst_miso", {31'h0, spi_miso}, 32'h0);
      check("midrst_oe", {31'h0, spi_miso_oe}, 32'h0);
      check("midrst_irq", {31'h0, irq_o}, 32'h0);
      model_reset();
      wait_clk(2);
      spi_cs_n = 1'b1; spi_mosi = 1'b0;
      wait_clk(2);
      rst_n = 1'b1;
      wait_clk(4);
      bus_read(8'h00);
      bus_read(8'h04);
      frame_data[0] = 8'hC6;
      spi_frame(1, 0);
      bus_read(8'h0C);

      // Drain and close
      while (m_rx.size() != 0) bus_read(8'h0C);
      bus_read(8'h0C);
      bus_read(8'h00);
      wait_clk(4);
      check("rd_queue_left", 32'(exp_rd_q.size()), 32'h0);
      check("miso_queue_left", 32'(exp_miso_q.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_target_mmio.md
# spi_target_mmio

SPI target (slave) peripheral with an MMIO register front-end. It receives 8-bit MSB-first frames from an external SPI controller on spi_sclk, spi_mosi and spi_cs_n, and returns a byte per frame on spi_miso. Pin inputs are oversampled in the clk domain, so no SCLK clock domain exists. It sits on the same mmio_if.slave bus as the SPI controller peripheral, with received bytes buffered in an RX FIFO and transmit bytes staged in a single holding register.

## Interface
- RX_DEPTH, 4: RX FIFO entries; power of two, 2..16.
- TX_IDLE, 8'hFF: byte shifted out when no TX byte is staged.
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- spi_sclk  in  1  SPI clock from the external controller.
- spi_mosi  in  1  controller-to-target data.
- spi_cs_n  in  1  chip select, active low.
- spi_miso  out  1  target-to-controller data; 0 while deselected.
- spi_miso_oe  out  1  output enable for the MISO pad; high while the synchronized CS is low and CTRL.EN=1.
- mmio  mmio_if.slave  -  mmio_valid, mmio_we, mmio_addr[ADDR_W-1:0], mmio_wdata[31:0], mmio_wstrb[3:0], mmio_rdata[31:0], mmio_ready, irq_o.

## Operation
- Bus: mmio_ready=1 always; fire = mmio_valid. Address decoding uses addr[7:0] with bits [1:0] forced to 0. Writes honour byte strobes. Unmapped reads return 0, and unmapped writes are ignored.
- 0x00 STATUS (R, W1C):
  - [0] RX_NE.
  - [1] RX_FULL.
  - [2] TX_EMPTY, meaning the holding register is free.
  - [3] OVR, sticky; write 1 to clear.
  - [4] SEL, the synchronized CS is low.
  - [12:8] RX_COUNT.
- 0x04 CTRL (RW):
  - [0] CPHA.
    - 0: sample MOSI on rising SCLK, shift MISO on falling SCLK.
    - 1: shift on rising SCLK, sample on falling SCLK.
  - [8] EN.
  - [9] FLUSH: write-1, self-clearing, reads 0; empties the RX FIFO.
  - [16] IRQ_RX_EN and [17] IRQ_OVR_EN: see Configuration.
- 0x08 TXDATA (W): writing wdata[7:0] loads the holding register and sets it valid. A write while the register is already valid overwrites it. Reads return 0.
- 0x0C RXDATA (R): a read returns {24'h0, head byte} and pops the FIFO. A read while the FIFO is empty returns 0 and does not pop.
- Sync: spi_sclk, spi_mosi and spi_cs_n each pass through 2 flops, plus 1 flop for edge detection. Edges are detected on the synchronized signals.
- Frame engine states:
  - IDLE → SEL on a CS falling edge with EN=1. On entry, clear the bit counter and load the shift register.
  - SEL → IDLE on a CS rising edge or when EN=0.
- Shift register load: the holding byte if it is valid, which also clears the valid flag; otherwise TX_IDLE.
- Sample edge:
  - shift_in = {shift_in[6:0], mosi}; bit counter +1.
  - When the counter reaches 8: push shift_in to the FIFO, reset the counter to 0, and reload the TX shift register per the load rule so that multi-byte frames run back to back.
- Shift edge: tx_shift <<= 1. With CPHA=1, the first shift edge of each byte is skipped so that bit 7 is presented first.
- spi_miso = tx_shift[7] while in SEL, otherwise 0.
- FIFO push while full: the byte is dropped, OVR is set, and the contents are unchanged.
- Simultaneous push and pop: RX_COUNT is unchanged and the ordering is preserved.
- FLUSH in the same cycle as a push: the FIFO ends empty; FLUSH wins.
- TXDATA write in the same cycle as a reload: the reload uses the pre-write state. If the register was valid, the old byte shifts and the new byte stays staged. If it was invalid, TX_IDLE shifts and the new byte stays staged.
- CS rising edge mid-byte: the partial byte is discarded and nothing is pushed. The next frame restarts at bit 7, and the holding register is untouched.

## Timing
- Reset values: spi_miso=0, spi_miso_oe=0, irq_o=0, mmio_rdata=0 for the idle bus.
- Register reset values: CTRL=32'h0000_0100 (EN=1, CPHA=0); FIFO empty; OVR=0; holding register invalid; state IDLE.
- Latency:
  - Pin edge to internal edge pulse: 3 clk.
  - Shift edge to spi_miso change: 3–4 clk.
  - Sample of the 8th bit to RX_NE=1: 1 clk after the edge pulse.
- Constraint: each SCLK high or low phase is at least 4 clk, i.e. SCLK ≤ clk/8. CS setup before the first SCLK edge is at least 4 clk.
- mmio_rdata is combinational from the current address. A pop takes effect at the clock edge ending the read cycle.
- Reset asserted mid-frame: all state clears asynchronously, and the frame in progress is lost.

## Configuration
- SPI_TGT_IRQ_EN defined: irq_o = (IRQ_RX_EN & RX_NE) | (IRQ_OVR_EN & OVR), registered, 1 clk after the status change. IRQ_RX_EN and IRQ_OVR_EN both reset to 0.
- SPI_TGT_IRQ_EN undefined: irq_o is tied to 0. CTRL[17:16] read 0 and writes to them are ignored.

## Test plan
- Basic receive, CPHA=0: controller sends 0xA5 → RX_COUNT=1; RXDATA read returns 0x000000A5; RX_NE=0 afterwards.
- Basic transmit: write TXDATA=0x3C, then the controller runs a 2-byte frame → MISO carries 0x3C then 0xFF; TX_EMPTY=1 after the first load.
- Overflow: 5 bytes 0x01..0x05 with RX_DEPTH=4 and no reads → reads return 01, 02, 03, 04 and OVR=1; writing 0x8 to STATUS clears OVR.
- Abort: CS rises after 5 bits of 0xFF → RX_COUNT=0; the next full byte 0x81 is received exactly.
- CPHA=1: set CTRL=0x101, TXDATA=0xC3, controller sends 0x5A → RX=0x5A and MISO=0xC3.
- IRQ (SPI_TGT_IRQ_EN defined): IRQ_RX_EN=1, receive one byte → irq_o=1; after the RXDATA read, irq_o=0 one clk later.
